mem_stage_nway: RTL

Parametrised successor to the dual-issue memory stage. It accepts an N-lane bundle from EX and drives a single SRAM-like data port (req/addr_ok/data_ok) for lane 0 loads and stores, with multi-cycle waits. It aligns load data (LB..LL), generates store strobes and SC results, and detects misaligned accesses itself. It arbitrates exceptions oldest-lane-first and presents a registered bundle to WB.

---
 rtl/mem_stage_nway.sv | 390 +++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_nway.sv
// N-lane memory stage: lane 0 drives an SRAM-like data port with load alignment,
// store strobes and SC/LL handling. Exceptions are picked from the oldest lane first.
module mem_stage_nway #(
    parameter int unsigned N_LANES    = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LANE_IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_LANES-1:0]      lane_valid_i,
    input  logic [5*N_LANES-1:0]    waddr_i,
    input  logic [N_LANES-1:0]      we_i,
    input  logic [32*N_LANES-1:0]   wdata_i,
    input  logic [32*N_LANES-1:0]   exc_vec_i,
    input  logic [3:0]              mem_op_i,
    input  logic [ADDR_W-1:0]       mem_addr_i,
    input  logic [31:0]             reg2_i,
    input  logic                    llbit_i,
    input  logic [31:0]             cp0_status_i,
    input  logic [31:0]             cp0_cause_i,
    output logic                    data_req,
    output logic                    data_wr,
    output logic [1:0]              data_size,
    output logic [3:0]              data_wstrb,
    output logic [ADDR_W-1:0]       data_addr,
    output logic [31:0]             data_wdata,
    input  logic                    data_addr_ok,
    input  logic                    data_data_ok,
    input  logic [31:0]             data_rdata,
    output logic                    out_valid,
    output logic [5*N_LANES-1:0]    waddr_o,
    output logic [N_LANES-1:0]      we_o,
    output logic [32*N_LANES-1:0]   wdata_o,
    output logic                    llbit_we_o,
    output logic                    llbit_o,
    output logic                    exc_flag_o,
    output logic [4:0]              exc_code_o,
    output logic [LANE_IDX_W-1:0]   exc_lane_o,
    output logic [ADDR_W-1:0]       badvaddr_o
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_LWL  = 4'd6;
    localparam logic [3:0] OP_LWR  = 4'd7;
    localparam logic [3:0] OP_LL   = 4'd8;
    localparam logic [3:0] OP_SB   = 4'd9;
    localparam logic [3:0] OP_SH   = 4'd10;
    localparam logic [3:0] OP_SW   = 4'd11;
    localparam logic [3:0] OP_SWL  = 4'd12;
    localparam logic [3:0] OP_SWR  = 4'd13;
    localparam logic [3:0] OP_SC   = 4'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_TR   = 5'h0d;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

    state_t state_q, state_d;
    logic   kill_q, kill_d;
    logic   outstanding_q;

    // Held bundle
    logic [5*N_LANES-1:0]  waddr_q;
    logic [N_LANES-1:0]    we_q;
    logic [32*N_LANES-1:0] wdata_q;
    logic [3:0]            op_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [31:0]           rt_q;
    logic                  exc_flag_q;
    logic [4:0]            exc_code_q;
    logic [LANE_IDX_W-1:0] exc_lane_q;
    logic [ADDR_W-1:0]     badvaddr_q;
    logic                  llbit_we_q;
    logic                  llbit_val_q;

    // Accept-time decode
    logic                  accept;
    logic                  mis_load, mis_store, int_pend;
    logic                  op_is_mem, go_req;
    logic [N_LANES-1:0]    lane_flag;
    logic [4:0]            lane_code [N_LANES];
    logic                  win_found;
    logic [4:0]            win_code;
    logic [LANE_IDX_W-1:0] win_idx;
    logic [N_LANES-1:0]    we_m;
    logic [32*N_LANES-1:0] acc_wdata;
    logic                  acc_ll_we, acc_ll_val;
    logic [ADDR_W-1:0]     acc_badvaddr;
    logic                  st_wr;
    logic [1:0]            st_size;
    logic [3:0]            st_wstrb;
    logic [ADDR_W-1:0]     st_addr;
    logic [31:0]           st_wdata;
    logic                  out_fire;
    logic                  unused_bits;

    assign unused_bits = ^{exc_vec_i, cp0_status_i, cp0_cause_i};

    assign accept    = (state_q == S_IDLE) && in_valid && !flush;
    assign int_pend  = (|(cp0_cause_i[15:8] & cp0_status_i[15:8])) && !cp0_status_i[1] && cp0_status_i[0];
    assign op_is_mem = lane_valid_i[0] && (mem_op_i != OP_NONE) && (mem_op_i <= OP_SC);
    assign go_req    = op_is_mem && !lane_flag[0] && ((mem_op_i != OP_SC) || llbit_i);
    assign out_fire  = (state_q == S_OUT) && !kill_q && !flush;

    // Aligned load result; LWL/LWR merge with the old rt value
    function automatic logic [31:0] load_align(input logic [3:0] op, input logic [1:0] b,
                                               input logic [31:0] rd, input logic [31:0] rt);
        logic [7:0]  by;
        logic [15:0] hw;
        logic [31:0] res;
        case (b)
            2'd0:    by = rd[7:0];
            2'd1:    by = rd[15:8];
            2'd2:    by = rd[23:16];
            default: by = rd[31:24];
        endcase
        hw  = b[1] ? rd[31:16] : rd[15:0];
        res = rd;
        case (op)
            OP_LB:  res = {{24{by[7]}}, by};
            OP_LBU: res = {24'd0, by};
            OP_LH:  res = {{16{hw[15]}}, hw};
            OP_LHU: res = {16'd0, hw};
            OP_LWL: begin
                case (b)
                    2'd0:    res = {rd[7:0], rt[23:0]};
                    2'd1:    res = {rd[15:0], rt[15:0]};
                    2'd2:    res = {rd[23:0], rt[7:0]};
                    default: res = rd;
                endcase
            end
            OP_LWR: begin
                case (b)
                    2'd0:    res = rd;
                    2'd1:    res = {rt[31:24], rd[31:8]};
                    2'd2:    res = {rt[31:16], rd[31:16]};
                    default: res = {rt[31:8], rd[31:24]};
                endcase
            end
            default: res = rd;
        endcase
        return res;
    endfunction

    always_comb begin
        mis_load  = 1'b0;
        mis_store = 1'b0;
        case (mem_op_i)
            OP_LH, OP_LHU: mis_load  = mem_addr_i[0];
            OP_LW, OP_LL:  mis_load  = |mem_addr_i[1:0];
            OP_SH:         mis_store = mem_addr_i[0];
            OP_SW, OP_SC:  mis_store = |mem_addr_i[1:0];
            default: ;
        endcase
    end

    // Per-lane exception priority, then oldest-lane arbitration and writeback masking
    always_comb begin
        logic [31:0] ev;
        logic        blk;
        ev        = '0;
        blk       = 1'b0;
        lane_flag = '0;
        win_found = 1'b0;
        win_code  = '0;
        win_idx   = '0;
        we_m      = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            lane_code[i] = '0;
            ev = exc_vec_i[32*i +: 32];
            if (lane_valid_i[i]) begin
                lane_flag[i] = 1'b1;
                if (i == 0 && int_pend)                  lane_code[i] = EXC_INT;
                else if (ev[4] || (i == 0 && mis_load))  lane_code[i] = EXC_ADEL;
                else if (ev[5] || (i == 0 && mis_store)) lane_code[i] = EXC_ADES;
                else if (ev[8])                          lane_code[i] = EXC_SYS;
                else if (ev[9])                          lane_code[i] = EXC_BP;
                else if (ev[10])                         lane_code[i] = EXC_RI;
                else if (ev[12])                         lane_code[i] = EXC_OV;
                else if (ev[13])                         lane_code[i] = EXC_TR;
                else if (ev[14])                         lane_code[i] = EXC_ERET;
                else                                     lane_flag[i] = 1'b0;
            end
            if (lane_flag[i] && !win_found) begin
                win_found = 1'b1;
                win_code  = lane_code[i];
                win_idx   = LANE_IDX_W'(i);
            end
            if (lane_flag[i]) blk = 1'b1;
            we_m[i] = we_i[i] && lane_valid_i[i] && !blk;
        end
    end

    always_comb begin
        acc_wdata    = wdata_i;
        acc_ll_we    = op_is_mem && !lane_flag[0] && ((mem_op_i == OP_LL) || (mem_op_i == OP_SC));
        acc_ll_val   = (mem_op_i == OP_LL);
        acc_badvaddr = '0;
        if (op_is_mem && (mem_op_i == OP_SC) && !lane_flag[0])
            acc_wdata[31:0] = {31'd0, go_req};
        if (lane_flag[0] && (((lane_code[0] == EXC_ADEL) && mis_load) ||
                             ((lane_code[0] == EXC_ADES) && mis_store)))
            acc_badvaddr = mem_addr_i;
    end

    // Data-port request fields
    always_comb begin
        st_wr    = 1'b0;
        st_size  = 2'd2;
        st_wstrb = 4'b0000;
        st_addr  = mem_addr_i;
        st_wdata = '0;
        case (mem_op_i)
            OP_LB, OP_LBU: st_size = 2'd0;
            OP_LH, OP_LHU: st_size = 2'd1;
            OP_LWL, OP_LWR: st_addr = {mem_addr_i[ADDR_W-1:2], 2'b00};
            OP_SB: begin
                st_wr    = 1'b1;
                st_size  = 2'd0;
                st_wstrb = 4'b0001 << mem_addr_i[1:0];
                st_wdata = {4{reg2_i[7:0]}};
            end
            OP_SH: begin
                st_wr    = 1'b1;
                st_size  = 2'd1;
                st_wstrb = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{reg2_i[15:0]}};
            end
            OP_SW, OP_SC: begin
                st_wr    = 1'b1;
                st_wstrb = 4'b1111;
                st_wdata = reg2_i;
            end
            OP_SWL: begin
                st_wr   = 1'b1;
                st_addr = {mem_addr_i[ADDR_W-1:2], 2'b00};
                case (mem_addr_i[1:0])
                    2'd0:    begin st_wstrb = 4'b0001; st_wdata = {24'd0, reg2_i[31:24]}; end
                    2'd1:    begin st_wstrb = 4'b0011; st_wdata = {16'd0, reg2_i[31:16]}; end
                    2'd2:    begin st_wstrb = 4'b0111; st_wdata = {8'd0, reg2_i[31:8]}; end
                    default: begin st_wstrb = 4'b1111; st_wdata = reg2_i; end
                endcase
            end
            OP_SWR: begin
                st_wr   = 1'b1;
                st_addr = {mem_addr_i[ADDR_W-1:2], 2'b00};
                case (mem_addr_i[1:0])
                    2'd0:    begin st_wstrb = 4'b1111; st_wdata = reg2_i; end
                    2'd1:    begin st_wstrb = 4'b1110; st_wdata = {reg2_i[23:0], 8'd0}; end
                    2'd2:    begin st_wstrb = 4'b1100; st_wdata = {reg2_i[15:0], 16'd0}; end
                    default: begin st_wstrb = 4'b1000; st_wdata = {reg2_i[7:0], 24'd0}; end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // A killed bundle still runs its bus transaction to completion so no response is orphaned
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = go_req ? S_REQ : S_OUT;
            S_REQ:   if (data_addr_ok) state_d = S_WAIT;
            S_WAIT:  if (outstanding_q && data_data_ok) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) kill_d = 1'b0;
        else if (flush)        kill_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kill_q        <= 1'b0;
            outstanding_q <= 1'b0;
        end else begin
            kill_q <= kill_d;
            if ((state_q == S_REQ) && data_addr_ok)
                outstanding_q <= 1'b1;
            else if ((state_q == S_WAIT) && data_data_ok)
                outstanding_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q     <= '0;
            we_q        <= '0;
            wdata_q     <= '0;
            op_q        <= OP_NONE;
            addr_q      <= '0;
            rt_q        <= '0;
            exc_flag_q  <= 1'b0;
            exc_code_q  <= '0;
            exc_lane_q  <= '0;
            badvaddr_q  <= '0;
            llbit_we_q  <= 1'b0;
            llbit_val_q <= 1'b0;
        end else begin
            if (accept) begin
                waddr_q     <= waddr_i;
                we_q        <= we_m;
                wdata_q     <= acc_wdata;
                op_q        <= mem_op_i;
                addr_q      <= mem_addr_i;
                rt_q        <= reg2_i;
                exc_flag_q  <= win_found;
                exc_code_q  <= win_code;
                exc_lane_q  <= win_idx;
                badvaddr_q  <= acc_badvaddr;
                llbit_we_q  <= acc_ll_we;
                llbit_val_q <= acc_ll_val;
            end
            if ((state_q == S_WAIT) && outstanding_q && data_data_ok &&
                (op_q >= OP_LB) && (op_q <= OP_LL))
                wdata_q[31:0] <= load_align(op_q, addr_q[1:0], data_rdata, rt_q);
        end
    end

    // Registered data port and WB bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b1;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= '0;
            data_wstrb <= '0;
            data_addr  <= '0;
            data_wdata <= '0;
            out_valid  <= 1'b0;
            waddr_o    <= '0;
            we_o       <= '0;
            wdata_o    <= '0;
            llbit_we_o <= 1'b0;
            llbit_o    <= 1'b0;
            exc_flag_o <= 1'b0;
            exc_code_o <= '0;
            exc_lane_o <= '0;
            badvaddr_o <= '0;
        end else begin
            in_ready <= (state_d == S_IDLE);
            data_req <= (state_d == S_REQ);
            if (accept && go_req) begin
                data_wr    <= st_wr;
                data_size  <= st_size;
                data_wstrb <= st_wstrb;
                data_addr  <= st_addr;
                data_wdata <= st_wdata;
            end else if ((state_q == S_REQ) && data_addr_ok) begin
                data_wr    <= 1'b0;
                data_size  <= '0;
                data_wstrb <= '0;
                data_addr  <= '0;
                data_wdata <= '0;
            end
            out_valid  <= out_fire;
            waddr_o    <= out_fire ? waddr_q : '0;
            we_o       <= out_fire ? we_q : '0;
            wdata_o    <= out_fire ? wdata_q : '0;
            llbit_we_o <= out_fire && llbit_we_q;
            llbit_o    <= out_fire && llbit_val_q;
            exc_flag_o <= out_fire && exc_flag_q;
            exc_code_o <= out_fire ? exc_code_q : '0;
            exc_lane_o <= out_fire ? exc_lane_q : '0;
            badvaddr_o <= out_fire ? badvaddr_q : '0;
        end
    end

endmodule
